ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
Multi-cycle controller for block transfers (LDM/STM). It walks a 16-bit register list lowest-index-first and drives the register file's select, write and uop ports. It also runs a req/ack word memory interface and performs optional base-register writeback. It sits in the execute stage beside the register file and takes ownership of its ports while busy.

Parameters:
UOP_WRITE, 5'd1, uop code presented to the register file on write cycles (must not be 0, 5 or 9).
UOP_IDLE, 5'd0, uop code presented on all other cycles (suppresses register file writes).

Ports:
clock  in  1  system clock, rising-edge logic
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
is_load  in  1  1=LDM, 0=STM
pre  in  1  1=address before transfer (IB/DB)
up  in  1  1=increment (IA/IB), 0=decrement (DA/DB)
writeback  in  1  write final address to base register
base_reg  in  4  base register index
base_addr  in  32  current base register value
reg_list  in  16  bit i set = transfer ri
pc_value  in  32  value stored when r15 is in an STM list
cur_flags  in  4  current flags, passed through on every rf write
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
rf_not_enable  out  1  low only on write cycles
rf_uop  out  5  UOP_WRITE on write cycles, otherwise UOP_IDLE
rf_sel_in, rf_sel_p0  out  4  register file write/read selects
rf_in_reg  out  32  register file write data
rf_in_flags  out  4  equals cur_flags
rf_p0  in  32  register file port 0 data (1-cycle read latency)
pc_write  out  1  one-cycle strobe: loaded value targets r15
pc_data  out  32  value for pc_write
mem_req, mem_we  out  1  memory request / write
mem_addr, mem_wdata  out  32  word address / store data
mem_ack  in  1  request accepted (store) or data valid (load)
mem_rdata  in  32  load data

Behaviour:
- Reset (asynchronous): state=IDLE. All 1-bit outputs are 0 except rf_not_enable=1. All buses are 0. rf_uop=UOP_IDLE. Reset mid-transfer aborts immediately with no further rf or memory writes.
- States: IDLE, SETUP, RD, MEM, WR, WB, DONE.
- IDLE, start=1: latch all inputs and compute n=popcount(reg_list) -> SETUP.
- SETUP (1 cycle): compute the start address.
  - IA: base
  - IB: base+4
  - DA: base-4n+4
  - DB: base-4n
  - final = up ? base+4n : base-4n (mod 2^32).
  - If n=0 -> DONE: no memory access, no writeback.
  - Otherwise pick the lowest set bit as idx. STM -> RD, LDM -> MEM.
- RD (STM only, 1 cycle): rf_sel_p0=idx; the register file captures p0 at the next edge -> MEM.
- MEM: mem_req=1, mem_we=!is_load.
  - mem_wdata = rf_p0, or pc_value when idx=15.
  - Address and data are held stable until a rising edge with mem_ack=1; ack in the first req cycle is legal.
  - On ack, LDM latches mem_rdata -> WR. On ack, STM goes to the next register.
- WR (1 cycle):
  - idx<15: rf_sel_in=idx, rf_in_reg=data, rf_not_enable=0, rf_uop=UOP_WRITE (the register file writes on the falling edge).
  - idx=15: pc_write=1, pc_data=data, with no rf write.
  - Then go to the next register.
- Next register: clear bit idx and add 4 to the address. If bits remain, take the lowest -> RD/MEM; else -> WB if writeback, else DONE.
- WB (1 cycle): rf write of final to base_reg.
  - Skipped (-> DONE, no write) if LDM and base_reg is in the list; the loaded value wins.
  - STM with base in the list stores the original value; writeback still occurs.
  - base_reg=15: pc_write instead of an rf write.
- DONE: done=1 for one cycle, busy=0 on the next cycle -> IDLE. start while busy is ignored.
- The flags register is never altered: rf_in_flags mirrors cur_flags.
- Latency with mem_ack tied high is 2+2n+(wb?1:0)+1 cycles from the start edge to done, for both LDM and STM.

Test Plan:
1. STM IA, list=0x000B (r0,r1,r3 = 0xA,0xB,0xD), base r2=0x100, wb=1, ack tied high -> writes 0xA@0x100, 0xB@0x104, 0xD@0x108. Then r2=0x10C, then done. Check done exactly 10 cycles after start.
2. LDM DB, list=0x0030, base=0x200, wb=1 -> reads 0x1F8->r4 and 0x1FC->r5; base=0x1F8. rf_not_enable low exactly 3 cycles; rf_in_flags=cur_flags throughout.
3. LDM IA, list=0x8001, base r0 in list, mem_ack delayed 3 cycles -> addr/req stable while waiting; r0 gets the loaded word; no writeback; pc_write=1 with the word from 0x104.
4. list=0x0000, wb=1 -> no mem_req and no rf write; done 3 cycles after start.
5. Reset asserted while in MEM of a 4-register LDM -> outputs go to reset values immediately. Next start runs normally.
6. start pulsed while busy -> ignored; no extra transfer occurs.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// Block-transfer (LDM/STM) sequencer: walks a register list lowest index first,
// drives register file ports and a req/ack word memory, then optional base writeback.
module ldm_stm_sequencer #(
    parameter logic [4:0] UOP_WRITE = 5'd1,
    parameter logic [4:0] UOP_IDLE  = 5'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre,
    input  logic        up,
    input  logic        writeback,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_addr,
    input  logic [15:0] reg_list,
    input  logic [31:0] pc_value,
    input  logic [3:0]  cur_flags,
    output logic        busy,
    output logic        done,
    output logic        rf_not_enable,
    output logic [4:0]  rf_uop,
    output logic [3:0]  rf_sel_in,
    output logic [3:0]  rf_sel_p0,
    output logic [31:0] rf_in_reg,
    output logic [3:0]  rf_in_flags,
    input  logic [31:0] rf_p0,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RD, S_MEM, S_WR, S_WB, S_DONE
    } state_t;

    typedef struct packed {
        logic        is_load;
        logic        pre;
        logic        up;
        logic        writeback;
        logic [3:0]  base_reg;
        logic [31:0] base_addr;
        logic [31:0] pc_value;
        logic [15:0] reg_list;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic [15:0] list_q;
    logic [4:0]  cnt_q;
    logic [31:0] addr_q, final_q, data_q;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    // Scans high to low so the lowest set bit is the one left standing.
    function automatic logic [3:0] lowest16(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    logic [3:0]  idx;
    logic [15:0] rest;
    logic [31:0] span, up_addr, dn_addr, start_addr, final_addr;
    logic        do_wb, advance;
    state_t      after_xfer;

    assign idx     = lowest16(list_q);
    assign rest    = list_q & (list_q - 16'd1);
    assign span    = {25'd0, cnt_q, 2'b00};
    assign up_addr = req_q.base_addr + span;
    assign dn_addr = req_q.base_addr - span;

    always_comb begin
        case ({req_q.up, req_q.pre})
            2'b10:   start_addr = req_q.base_addr;
            2'b11:   start_addr = req_q.base_addr + 32'd4;
            2'b00:   start_addr = dn_addr + 32'd4;
            default: start_addr = dn_addr;
        endcase
    end

    assign final_addr = req_q.up ? up_addr : dn_addr;
    // An LDM that reloads its own base keeps the loaded value, not the writeback.
    assign do_wb      = req_q.writeback &&
                        !(req_q.is_load && req_q.reg_list[req_q.base_reg]);
    assign advance    = (state == S_MEM && mem_ack && !req_q.is_load) || state == S_WR;

    always_comb begin
        if (rest != 16'd0)  after_xfer = req_q.is_load ? S_MEM : S_RD;
        else if (do_wb)     after_xfer = S_WB;
        else                after_xfer = S_DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: begin
                if (cnt_q == 5'd0)      state_nxt = S_DONE;
                else if (req_q.is_load) state_nxt = S_MEM;
                else                    state_nxt = S_RD;
            end
            S_RD:    state_nxt = S_MEM;
            S_MEM:   if (mem_ack) state_nxt = req_q.is_load ? S_WR : after_xfer;
            S_WR:    state_nxt = after_xfer;
            S_WB:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q   <= '0;
            list_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            final_q <= '0;
            data_q  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                req_q.is_load   <= is_load;
                req_q.pre       <= pre;
                req_q.up        <= up;
                req_q.writeback <= writeback;
                req_q.base_reg  <= base_reg;
                req_q.base_addr <= base_addr;
                req_q.pc_value  <= pc_value;
                req_q.reg_list  <= reg_list;
                list_q          <= reg_list;
                cnt_q           <= popcount16(reg_list);
            end
            if (state == S_SETUP) begin
                addr_q  <= start_addr;
                final_q <= final_addr;
            end
            if (state == S_MEM && mem_ack && req_q.is_load) data_q <= mem_rdata;
            if (advance) begin
                list_q <= rest;
                addr_q <= addr_q + 32'd4;
            end
        end
    end

    assign rf_in_flags = cur_flags;

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rf_not_enable = 1'b1;
        rf_uop        = UOP_IDLE;
        rf_sel_in     = '0;
        rf_sel_p0     = '0;
        rf_in_reg     = '0;
        pc_write      = 1'b0;
        pc_data       = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            S_IDLE: ;
            S_SETUP: busy = 1'b1;
            S_RD: begin
                busy      = 1'b1;
                rf_sel_p0 = idx;
            end
            S_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !req_q.is_load;
                mem_addr = addr_q;
                // Holding the read select keeps rf_p0 steady until the store is accepted.
                if (!req_q.is_load) begin
                    rf_sel_p0 = idx;
                    mem_wdata = (idx == 4'd15) ? req_q.pc_value : rf_p0;
                end
            end
            S_WR: begin
                busy = 1'b1;
                if (idx == 4'd15) begin
                    pc_write = 1'b1;
                    pc_data  = data_q;
                end else begin
                    rf_not_enable = 1'b0;
                    rf_uop        = UOP_WRITE;
                    rf_sel_in     = idx;
                    rf_in_reg     = data_q;
                end
            end
            S_WB: begin
                busy = 1'b1;
                if (req_q.base_reg == 4'd15) begin
                    pc_write = 1'b1;
                    pc_data  = final_q;
                end else begin
                    rf_not_enable = 1'b0;
                    rf_uop        = UOP_WRITE;
                    rf_sel_in     = req_q.base_reg;
                    rf_in_reg     = final_q;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register file and req/ack memory model.
module tb_ldm_stm_sequencer;

    logic        clock, reset, start, is_load, pre, up, writeback;
    logic [3:0]  base_reg, cur_flags, rf_sel_in, rf_sel_p0, rf_in_flags;
    logic [31:0] base_addr, pc_value, rf_in_reg, rf_p0, pc_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] reg_list;
    logic        busy, done, rf_not_enable, pc_write, mem_req, mem_we, mem_ack;
    logic [4:0]  rf_uop;

    ldm_stm_sequencer #(.UOP_WRITE(5'd1), .UOP_IDLE(5'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .is_load(is_load),
        .pre(pre), .up(up), .writeback(writeback), .base_reg(base_reg),
        .base_addr(base_addr), .reg_list(reg_list), .pc_value(pc_value),
        .cur_flags(cur_flags), .busy(busy), .done(done),
        .rf_not_enable(rf_not_enable), .rf_uop(rf_uop), .rf_sel_in(rf_sel_in),
        .rf_sel_p0(rf_sel_p0), .rf_in_reg(rf_in_reg), .rf_in_flags(rf_in_flags),
        .rf_p0(rf_p0), .pc_write(pc_write), .pc_data(pc_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] rf [16];
    int cyc = 0;
    int wait_cnt = 0;
    int ack_delay = 0;
    int n_chk = 0;
    int n_err = 0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rf_p0 <= rf[rf_sel_p0];
    end

    always @(posedge clock or posedge reset) begin
        if (reset)                  wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                        wait_cnt <= 0;
    end

    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_addr ^ 32'h5A5A0000;

    always @(negedge clock)
        if (!reset && !rf_not_enable && rf_uop == 5'd1) rf[rf_sel_in] = rf_in_reg;

    logic [31:0] st_addr[$], st_data[$], rw_data[$];
    logic [3:0]  rw_sel[$];
    int done_cyc, done_cnt, req_cyc, acc_cnt, unstable, ne_low, pcw_cnt, flags_bad, uop_bad;
    logic [31:0] pcw_data, pend_addr, pend_wdata;
    logic        pend, pend_we;

    initial begin
        done_cnt = 0;
        pend     = 1'b0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin done_cyc = cyc; done_cnt++; end
            if (mem_req) begin
                req_cyc++;
                if (pend && (mem_addr !== pend_addr || mem_we !== pend_we ||
                             (mem_we && mem_wdata !== pend_wdata))) unstable++;
                if (mem_ack) begin
                    acc_cnt++;
                    if (mem_we) begin st_addr.push_back(mem_addr); st_data.push_back(mem_wdata); end
                end
            end
            pend = mem_req && !mem_ack;
            pend_addr = mem_addr; pend_we = mem_we; pend_wdata = mem_wdata;
            if (!rf_not_enable) begin
                ne_low++;
                rw_sel.push_back(rf_sel_in);
                rw_data.push_back(rf_in_reg);
                if (rf_uop !== 5'd1) uop_bad++;
            end else if (rf_uop !== 5'd0) uop_bad++;
            if (pc_write) begin pcw_cnt++; pcw_data = pc_data; end
            if (busy && rf_in_flags !== cur_flags) flags_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q32(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEADDEAD;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        st_addr.delete(); st_data.delete(); rw_sel.delete(); rw_data.delete();
        req_cyc = 0; acc_cnt = 0; unstable = 0; ne_low = 0;
        pcw_cnt = 0; pcw_data = '0; flags_bad = 0; uop_bad = 0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int bound;
        bound = 0;
        while (done_cnt == d0 && bound < 200) begin tick(1); bound++; end
        chk({tag, "_timeout"}, 32'(done_cnt == d0), 32'd0);
    endtask

    // Latency counts the start cycle as cycle 1 and the done cycle inclusive.
    task automatic do_xfer(input logic ld, input logic pr, input logic u, input logic w,
                           input logic [3:0] br, input logic [31:0] ba,
                           input logic [15:0] lst, input string tag, output int lat);
        int d0, t0;
        d0 = done_cnt;
        is_load = ld; pre = pr; up = u; writeback = w;
        base_reg = br; base_addr = ba; reg_list = lst;
        start = 1'b1; t0 = cyc;
        tick(1);
        start = 1'b0;
        wait_done(d0, tag);
        lat = done_cyc - t0 + 1;
        tick(2);
    endtask

    int lat, d0;

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b1;
        writeback = 1'b0; base_reg = '0; base_addr = '0; reg_list = '0;
        pc_value = 32'h0000_8000; cur_flags = 4'h0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        clear_logs();
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ne", rf_not_enable, 1);
        chk("rst_uop", rf_uop, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pcw", pc_write, 0);
        reset = 1'b0;
        tick(2);

        // 1: STM IA r0,r1,r3 base r2 with writeback
        rf[0] = 32'hA; rf[1] = 32'hB; rf[3] = 32'hD; rf[2] = 32'h100;
        cur_flags = 4'h5; ack_delay = 0; clear_logs();
        do_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h100, 16'h000B, "t1", lat);
        chk("t1_nst", st_addr.size(), 3);
        chk("t1_a0", q32(st_addr, 0), 32'h100); chk("t1_d0", q32(st_data, 0), 32'hA);
        chk("t1_a1", q32(st_addr, 1), 32'h104); chk("t1_d1", q32(st_data, 1), 32'hB);
        chk("t1_a2", q32(st_addr, 2), 32'h108); chk("t1_d2", q32(st_data, 2), 32'hD);
        chk("t1_r2", rf[2], 32'h10C);
        chk("t1_nrw", rw_data.size(), 1);
        chk("t1_lat", lat, 10);
        chk("t1_flags", flags_bad, 0);

        // 2: LDM DB r4,r5 base r6 with writeback
        rf[6] = 32'h200; cur_flags = 4'hA; clear_logs();
        do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h200, 16'h0030, "t2", lat);
        chk("t2_r4", rf[4], 32'h5A5A01F8);
        chk("t2_r5", rf[5], 32'h5A5A01FC);
        chk("t2_r6", rf[6], 32'h1F8);
        chk("t2_nelow", ne_low, 3);
        chk("t2_flags", flags_bad, 0);
        chk("t2_uop", uop_bad, 0);
        chk("t2_nst", st_addr.size(), 0);
        chk("t2_lat", lat, 8);

        // 3: LDM IA r0,r15 base r0 in list, slow ack
        ack_delay = 3; cur_flags = 4'h3; clear_logs();
        do_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h8001, "t3", lat);
        chk("t3_r0", rf[0], 32'h5A5A0100);
        chk("t3_pcw", pcw_cnt, 1);
        chk("t3_pcd", pcw_data, 32'h5A5A0104);
        chk("t3_nrw", rw_data.size(), 1);
        chk("t3_stable", unstable, 0);
        chk("t3_reqcyc", req_cyc, 8);
        chk("t3_lat", lat, 13);

        // 4: empty list
        ack_delay = 0; clear_logs();
        do_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 32'h700, 16'h0000, "t4", lat);
        chk("t4_req", req_cyc, 0);
        chk("t4_nelow", ne_low, 0);
        chk("t4_pcw", pcw_cnt, 0);
        chk("t4_lat", lat, 3);

        // 5: reset in MEM of a 4-register LDM, then a clean STM
        ack_delay = 3; clear_logs();
        is_load = 1'b1; pre = 1'b0; up = 1'b1; writeback = 1'b1;
        base_reg = 4'd1; base_addr = 32'h300; reg_list = 16'h00F0;
        start = 1'b1; tick(1); start = 1'b0;
        for (int b = 0; b < 20 && !mem_req; b++) tick(1);
        chk("t5_inmem", mem_req, 1);
        tick(1);
        reset = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_req", mem_req, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_ne", rf_not_enable, 1);
        chk("t5_uop", rf_uop, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("t5_norw", ne_low, 0);
        chk("t5_noacc", acc_cnt, 0);
        ack_delay = 0; rf[0] = 32'h11; rf[1] = 32'h22; clear_logs();
        do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h400, 16'h0003, "t5b", lat);
        chk("t5b_nst", st_addr.size(), 2);
        chk("t5b_a0", q32(st_addr, 0), 32'h400); chk("t5b_d0", q32(st_data, 0), 32'h11);
        chk("t5b_a1", q32(st_addr, 1), 32'h404); chk("t5b_d1", q32(st_data, 1), 32'h22);
        chk("t5b_lat", lat, 7);

        // 6: second start while busy must be ignored
        clear_logs(); d0 = done_cnt;
        is_load = 1'b1; pre = 1'b0; up = 1'b1; writeback = 1'b0;
        base_reg = 4'd9; base_addr = 32'h500; reg_list = 16'h0004;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        reg_list = 16'hFFFF; start = 1'b1; tick(1); start = 1'b0;
        wait_done(d0, "t6");
        tick(6);
        chk("t6_acc", acc_cnt, 1);
        chk("t6_r2", rf[2], 32'h5A5A0500);
        chk("t6_nrw", rw_data.size(), 1);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
